// File: rtl/vga_color_sequencer.sv
// Steps a small colour palette once every FRAMES_PER_STEP video frames and
// drives the selected colour to the line generator, updating only at frame edges.
module vga_color_sequencer #(
  parameter int NUM_COLORS      = 4,
  parameter int FRAMES_PER_STEP = 60,
  parameter int IW              = $clog2(NUM_COLORS)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          VGA_VSYNC,
  input  logic          WR_VALID,
  output logic          WR_READY,
  input  logic [IW-1:0] WR_ADDR,
  input  logic [11:0]   WR_DATA,
  output logic [11:0]   RGB,
  output logic [IW-1:0] IDX,
  output logic          STEP,
  output logic          DBG_STATE
);

  localparam int FCW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state;
  logic           vs_q;
  logic           fe;
  logic           ready_q;
  logic           wr_fire;
  logic [FCW-1:0] fc;
  logic [IW-1:0]  idx_next;
  logic [11:0]    palette [NUM_COLORS];

  function automatic logic [11:0] reset_color(input int i);
    case (i)
      1:       return 12'h0F0;
      2:       return 12'h00F;
      3:       return 12'hF00;
      default: return 12'h000;
    endcase
  endfunction

  // Write handshake: a write is taken when WR_VALID and WR_READY are both high
  // at a clock edge; the requester holds WR_VALID/WR_ADDR/WR_DATA until then.
  // READY drops during frame-edge cycles so the palette is stable while RGB loads.
  assign fe        = vs_q & ~VGA_VSYNC;
  assign WR_READY  = ready_q & ~fe & ~RST;
  assign wr_fire   = WR_VALID & WR_READY;
  assign idx_next  = IDX + IW'(1);
  assign DBG_STATE = (state == RUN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_COLORS; i++) begin
        palette[i] <= reset_color(i);
      end
    end else if (wr_fire) begin
      palette[WR_ADDR] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= HOLD;
      vs_q    <= 1'b1;
      ready_q <= 1'b0;
      fc      <= '0;
      IDX     <= '0;
      RGB     <= 12'h000;
      STEP    <= 1'b0;
    end else begin
      vs_q    <= VGA_VSYNC;
      ready_q <= 1'b1;
      STEP    <= 1'b0;
      state   <= EN ? RUN : HOLD;
      if (fe) begin
        if (state == RUN && fc == FC_LAST) begin
          fc   <= '0;
          IDX  <= idx_next;
          RGB  <= palette[idx_next];
          STEP <= 1'b1;
        end else begin
          // HOLD freezes the counter but still reloads the current colour.
          if (state == RUN) begin
            fc <= fc + FCW'(1);
          end
          RGB <= palette[IDX];
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Bench for vga_color_sequencer with four colours and two frames per step;
// a palette/index model queues the expected colour, index and step per frame edge.
module tb_vga_color_sequencer;

  localparam int NC  = 4;
  localparam int FPS = 2;
  localparam int IW  = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          EN;
  logic          VGA_VSYNC;
  logic          WR_VALID;
  logic          WR_READY;
  logic [IW-1:0] WR_ADDR;
  logic [11:0]   WR_DATA;
  logic [11:0]   RGB;
  logic [IW-1:0] IDX;
  logic          STEP;
  logic          DBG_STATE;

  always #5 CLK = ~CLK;

  vga_color_sequencer #(
    .NUM_COLORS      (NC),
    .FRAMES_PER_STEP (FPS),
    .IW              (IW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .VGA_VSYNC (VGA_VSYNC),
    .WR_VALID  (WR_VALID),
    .WR_READY  (WR_READY),
    .WR_ADDR   (WR_ADDR),
    .WR_DATA   (WR_DATA),
    .RGB       (RGB),
    .IDX       (IDX),
    .STEP      (STEP),
    .DBG_STATE (DBG_STATE)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [11:0] m_pal [NC];
  int          m_idx;
  int          m_fc;
  logic [14:0] exp_q [$];
  logic [11:0] rgb_tab [8] = '{12'h000, 12'h0F0, 12'h0F0, 12'h00F,
                               12'h00F, 12'hF00, 12'hF00, 12'h000};
  logic        step_tab [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_reset();
    m_pal[0] = 12'h000;
    m_pal[1] = 12'h0F0;
    m_pal[2] = 12'h00F;
    m_pal[3] = 12'hF00;
    m_idx    = 0;
    m_fc     = 0;
    exp_q.delete();
  endtask

  task automatic model_fe();
    logic step;
    step = 1'b0;
    if (EN) begin
      if (m_fc == FPS - 1) begin
        m_fc  = 0;
        m_idx = (m_idx + 1) % NC;
        step  = 1'b1;
      end else begin
        m_fc++;
      end
    end
    exp_q.push_back({IW'(m_idx), step, m_pal[m_idx]});
  endtask

  task automatic compare_out();
    logic [14:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_queue: got empty expected entry");
    end else begin
      e = exp_q.pop_front();
      check("rgb", RGB, e[11:0]);
      check("step", STEP, e[12]);
      check("idx", IDX, e[14:13]);
    end
  endtask

  task automatic frame_edge();
    repeat ($urandom_range(1, 4)) tick();
    VGA_VSYNC = 1'b0;
    #1;
    check("ready_in_fe", WR_READY, 0);
    model_fe();
    tick();
    VGA_VSYNC = 1'b1;
    compare_out();
    tick();
    check("step_one_cycle", STEP, 0);
  endtask

  task automatic write_entry(input logic [IW-1:0] a, input logic [11:0] d);
    logic accepted;
    accepted = 1'b0;
    WR_VALID = 1'b1;
    WR_ADDR  = a;
    WR_DATA  = d;
    for (int i = 0; i < 10; i++) begin
      #1;
      accepted = WR_READY;
      tick();
      if (accepted) begin
        m_pal[a] = d;
        break;
      end
    end
    WR_VALID = 1'b0;
    check("write_accepted", accepted, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] rgb_before;
    RST = 1'b1; EN = 1'b0; VGA_VSYNC = 1'b1;
    WR_VALID = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    repeat (3) tick();
    check("rst_rgb", RGB, 12'h000);
    check("rst_idx", IDX, 0);
    check("rst_step", STEP, 0);
    check("rst_ready", WR_READY, 0);

    RST = 1'b0;
    model_reset();
    #1;
    check("ready_reset_cycle", WR_READY, 0);
    tick();
    check("ready_after_reset", WR_READY, 1);

    // Eight frames through the full palette, ending on the 3 -> 0 wrap.
    EN = 1'b1;
    tick();
    check("state_run", DBG_STATE, 1);
    for (int i = 0; i < 8; i++) begin
      check("seq_step_expect", exp_q.size(), 0);
      frame_edge();
      check("seq_rgb_table", RGB, rgb_tab[i]);
      if (step_tab[i]) check("seq_wrap_idx_progress", IDX, ((i + 1) / 2) % NC);
    end
    check("wrap_idx", IDX, 0);

    // Mid-frame write with IDX = 1 only shows up at the next frame edge.
    frame_edge();
    frame_edge();
    check("idx_before_write", IDX, 1);
    rgb_before = RGB;
    write_entry(2'd1, 12'hABC);
    repeat (3) tick();
    check("rgb_hold_after_write", RGB, rgb_before);
    check("rgb_hold_const", RGB, 12'h0F0);
    frame_edge();
    check("rgb_new_entry", RGB, 12'hABC);

    // Write held across a frame edge: refused in the edge cycle, taken the next.
    tick();
    WR_VALID = 1'b1; WR_ADDR = 2'd2; WR_DATA = 12'h123; VGA_VSYNC = 1'b0;
    #1;
    check("ready_fe_with_write", WR_READY, 0);
    model_fe();
    tick();
    VGA_VSYNC = 1'b1;
    compare_out();
    check("rgb_old_entry2", RGB, 12'h00F);
    check("ready_after_fe", WR_READY, 1);
    tick();
    WR_VALID = 1'b0;
    m_pal[2] = 12'h123;
    check("step_after_fe_write", STEP, 0);
    frame_edge();
    check("rgb_entry2_written", RGB, 12'h123);

    // Hold for three frames, then resume from the preserved frame count.
    EN = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      frame_edge();
      check("hold_idx", IDX, 2);
    end
    check("state_hold", DBG_STATE, 0);
    EN = 1'b1;
    frame_edge();
    check("resume_idx", IDX, 3);
    check("resume_rgb", RGB, 12'hF00);
    frame_edge();

    // Reset coincident with a frame edge and a write request.
    RST = 1'b1; VGA_VSYNC = 1'b0; WR_VALID = 1'b1; WR_ADDR = 2'd0; WR_DATA = 12'hFFF;
    tick();
    RST = 1'b0; VGA_VSYNC = 1'b1; WR_VALID = 1'b0;
    model_reset();
    check("rst_fe_idx", IDX, 0);
    check("rst_fe_rgb", RGB, 12'h000);
    check("rst_fe_step", STEP, 0);
    check("rst_fe_ready", WR_READY, 0);
    frame_edge();
    check("rst_write_discarded", RGB, 12'h000);
    frame_edge();
    check("rst_palette_restored", RGB, 12'h0F0);
    check("rst_restart_idx", IDX, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
